rx_frame_receiver: RTL and testbench
====================================

Name: rx_frame_receiver

Overview:
- Receive-side framing stage directly upstream of the prefetcher.
- Watches the IO_BITS-wide rx_pins bus and detects response frames: start, SBS header cycle, PAYLOAD_CYCLES payload cycles.
- Generates the rx_* strobes and counter consumed by the prefetcher and by the load/store path.
- Tracks outstanding read requests in an in-order kind queue, so prefetch payload is flagged separately from load payload.

Parameters:
- IO_BITS, 2, width of the rx pin bus and payload beat.
- PAYLOAD_CYCLES, 8, payload beats per 16-bit response.
- MAX_OUTSTANDING, 3, capacity of the outstanding-request kind queue.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- rx_pins  in  IO_BITS  serial receive bus; idle level has rx_pins[0]=1.
- req_issued  in  1  one-cycle pulse: a read request was sent (from the tx side).
- req_is_prefetch  in  1  kind of the issued request; valid with req_issued.
- rx_started  out  1  high in the cycle a start is detected.
- rx_active  out  1  high from the SBS cycle through the last payload cycle.
- rx_sbs  out  IO_BITS  registered SBS header value.
- rx_sbs_valid  out  1  high during the SBS cycle.
- rx_data_valid  out  1  payload beat on rx_pins belongs to a prefetch response.
- rx_ldata_valid  out  1  payload beat on rx_pins belongs to a load response.
- rx_counter  out  $clog2(PAYLOAD_CYCLES)+1  payload beat index.
- rx_done  out  1  last beat of a prefetch payload.
- rx_ldone  out  1  last beat of a load payload.
- queue_full  out  1  kind queue holds MAX_OUTSTANDING entries.
- protocol_error  out  1  sticky error flag.

Behaviour:
- State machine: IDLE -> SBS -> PAYLOAD -> IDLE.
- IDLE:
  - rx_pins[0]==0 asserts rx_started combinationally and moves to SBS next cycle.
  - rx_pins[0]==1 stays in IDLE.
- SBS: exactly one cycle.
  - rx_sbs_valid=1; rx_sbs is captured from rx_pins.
  - Next state is PAYLOAD if the SBS is 2'b01 and the queue is non-empty.
  - Any other SBS value: go to IDLE and pop nothing.
  - SBS 2'b01 with an empty queue: set protocol_error and go to IDLE.
- PAYLOAD:
  - rx_counter counts 0..PAYLOAD_CYCLES-1, one beat per cycle.
  - rx_data_valid = head kind is prefetch; rx_ldata_valid = head kind is load.
  - At counter PAYLOAD_CYCLES-1, assert rx_done or rx_ldone according to head kind, pop the head and return to IDLE.
  - Start is not sampled during PAYLOAD; the earliest next start is detected in the cycle after the last beat.
- rx_active = (state != IDLE).
- rx_counter is 0 outside PAYLOAD; its MSB is always 0 in this block (extra bit is for consumer compatibility).
- Kind queue: in-order FIFO of 1-bit kinds, depth MAX_OUTSTANDING, occupancy counter width $clog2(MAX_OUTSTANDING+1).
  - Simultaneous push and pop: occupancy unchanged; the push lands behind the popped head.
  - Push when full with no pop in the same cycle: drop the push and set protocol_error.
  - A push is visible as head no earlier than the next cycle.
- protocol_error clears only on reset.
- Reset (async, may hit mid-frame):
  - state=IDLE, queue empty, rx_counter=0, rx_sbs=0, protocol_error=0.
  - All strobes low.
- Latency: pin to strobe is combinational through state. Outputs for a given beat coincide with that beat on rx_pins; consumers sample rx_pins directly.

Optional Feature:
- RX_PIN_SYNC_EN defined: rx_pins pass through a 2-flop synchronizer (reset value all-ones) before all logic.
  - All rx_* strobes are delayed 2 cycles relative to the raw pins.
  - An rx_pins_synced output (IO_BITS) is added; consumers must sample it instead of raw rx_pins.
- RX_PIN_SYNC_EN undefined: raw pins are used directly; no rx_pins_synced port.

Test Plan:
- Issue prefetch request, then drive start, SBS=01 and 8 beats (payload 0x1234, LSB beat first) -> rx_started 1 cycle; rx_data_valid for 8 cycles with rx_counter 0..7; rx_done at counter 7; queue empty afterwards.
- Issue load then prefetch, then two back-to-back frames (second start immediately after the first frame's last beat) -> first frame gives rx_ldata_valid/rx_ldone, second gives rx_data_valid/rx_done; no beat lost.
- Frame with SBS=01 and no outstanding request -> protocol_error=1, state returns to IDLE after SBS, no payload strobes.
- Issue 3 requests, then a 4th -> queue_full=1 after the 3rd; the 4th is dropped and sets protocol_error. Push and pop in the same cycle at full -> occupancy stays 3.
- Assert reset low at rx_counter=4 mid-payload -> all outputs 0 immediately (asynchronously), queue empty; a subsequent frame with an empty queue flags an error.
- With RX_PIN_SYNC_EN defined: same stimulus as the first scenario -> every strobe shifted exactly 2 cycles later; rx_pins_synced carries the payload.

Source files
------------

// File: rtl/rx_frame_receiver.sv
// Receive-side framer: detects start/SBS/payload frames on rx_pins and tags each payload with the
// kind of the oldest outstanding read. Define RX_PIN_SYNC_EN to add a 2-flop pin synchronizer.
module rx_frame_receiver #(
  parameter int IO_BITS         = 2,
  parameter int PAYLOAD_CYCLES  = 8,
  parameter int MAX_OUTSTANDING = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [IO_BITS-1:0]                rx_pins,
  input  logic                              req_issued,
  input  logic                              req_is_prefetch,
  output logic                              rx_started,
  output logic                              rx_active,
  output logic [IO_BITS-1:0]                rx_sbs,
  output logic                              rx_sbs_valid,
  output logic                              rx_data_valid,
  output logic                              rx_ldata_valid,
  output logic [$clog2(PAYLOAD_CYCLES):0]   rx_counter,
  output logic                              rx_done,
  output logic                              rx_ldone,
  output logic                              queue_full,
  output logic                              protocol_error
`ifdef RX_PIN_SYNC_EN
  ,
  output logic [IO_BITS-1:0]                rx_pins_synced
`endif
);

  // state   | meaning
  // IDLE    | waiting for rx_pins[0] low (start)
  // SBS     | single header cycle, decides payload or abort
  // PAYLOAD | PAYLOAD_CYCLES beats tagged with the head request kind

  localparam int CW = $clog2(PAYLOAD_CYCLES) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [IO_BITS-1:0] SBS_READ  = IO_BITS'(1);
  localparam logic [CW-1:0]      LAST_BEAT = CW'(PAYLOAD_CYCLES - 1);
  localparam logic [OW-1:0]      DEPTH     = OW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, SBS, PAYLOAD} state_t;

  state_t                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [IO_BITS-1:0]           sbs_q, sbs_d;
  logic                         err_q, err_d;
  logic [MAX_OUTSTANDING-1:0]   kind_q, kind_d;
  logic [OW-1:0]                occ_q, occ_d;
  logic [IO_BITS-1:0]           pins;
  logic                         head;
  logic                         pop;

`ifdef RX_PIN_SYNC_EN
  logic [IO_BITS-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= rx_pins;
      sync2_q <= sync1_q;
    end
  end

  assign pins           = sync2_q;
  assign rx_pins_synced = sync2_q;
`else
  assign pins = rx_pins;
`endif

  assign head           = kind_q[0];
  assign rx_active      = (state_q != IDLE);
  assign rx_counter     = cnt_q;
  assign rx_sbs         = sbs_q;
  assign protocol_error = err_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = '0;
    sbs_d          = sbs_q;
    err_d          = err_q;
    kind_d         = kind_q;
    occ_d          = occ_q;
    pop            = 1'b0;
    rx_started     = 1'b0;
    rx_sbs_valid   = 1'b0;
    rx_data_valid  = 1'b0;
    rx_ldata_valid = 1'b0;
    rx_done        = 1'b0;
    rx_ldone       = 1'b0;
    queue_full     = (occ_q == DEPTH);

    case (state_q)
      IDLE: begin
        // gated so a low pin cannot raise a strobe while reset is held
        if (!pins[0]) begin
          rx_started = reset;
          state_d    = SBS;
        end
      end
      SBS: begin
        rx_sbs_valid = 1'b1;
        sbs_d        = pins;
        state_d      = IDLE;
        if (pins == SBS_READ) begin
          if (occ_q != '0) state_d = PAYLOAD;
          else             err_d   = 1'b1;
        end
      end
      PAYLOAD: begin
        rx_data_valid  = head;
        rx_ldata_valid = !head;
        if (cnt_q == LAST_BEAT) begin
          rx_done  = head;
          rx_ldone = !head;
          pop      = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // head sits in bit 0; a push in the pop cycle lands behind the shifted queue
    if (pop) begin
      kind_d = kind_q >> 1;
      occ_d  = occ_q - 1'b1;
    end
    if (req_issued) begin
      if (queue_full && !pop) begin
        err_d = 1'b1;
      end else begin
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
          if (occ_d == OW'(i)) kind_d[i] = req_is_prefetch;
        end
        occ_d = occ_d + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sbs_q   <= '0;
      err_q   <= 1'b0;
      kind_q  <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sbs_q   <= sbs_d;
      err_q   <= err_d;
      kind_q  <= kind_d;
      occ_q   <= occ_d;
    end
  end

endmodule

// File: tb/tb_rx_frame_receiver.sv
// Scoreboard bench for rx_frame_receiver; expected strobe events are queued by the stimulus
// and popped by a monitor whenever the DUT raises any strobe.
module tb_rx_frame_receiver;

`ifdef RX_PIN_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk;
  logic       reset;
  logic [1:0] rx_pins;
  logic       req_issued;
  logic       req_is_prefetch;
  logic       rx_started, rx_active, rx_sbs_valid, rx_data_valid, rx_ldata_valid;
  logic [1:0] rx_sbs;
  logic [3:0] rx_counter;
  logic       rx_done, rx_ldone, queue_full, protocol_error;
`ifdef RX_PIN_SYNC_EN
  logic [1:0] rx_pins_synced;
`endif

  rx_frame_receiver dut (
    .clk             (clk),
    .reset           (reset),
    .rx_pins         (rx_pins),
    .req_issued      (req_issued),
    .req_is_prefetch (req_is_prefetch),
    .rx_started      (rx_started),
    .rx_active       (rx_active),
    .rx_sbs          (rx_sbs),
    .rx_sbs_valid    (rx_sbs_valid),
    .rx_data_valid   (rx_data_valid),
    .rx_ldata_valid  (rx_ldata_valid),
    .rx_counter      (rx_counter),
    .rx_done         (rx_done),
    .rx_ldone        (rx_ldone),
    .queue_full      (queue_full),
`ifdef RX_PIN_SYNC_EN
    .rx_pins_synced  (rx_pins_synced),
`endif
    .protocol_error  (protocol_error)
  );

  typedef struct packed {
    int         cyc;
    logic       st;
    logic       act;
    logic       sv;
    logic       dv;
    logic       ldv;
    logic [3:0] cnt;
    logic       dn;
    logic       ldn;
    logic [1:0] pins;
  } ev_t;

  ev_t        sb[$];
  ev_t        tmpl[$];
  logic [1:0] seq[$];
  int         cyc   = 0;
  int         total = 0;
  int         bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic kind);
    req_issued      = 1'b1;
    req_is_prefetch = kind;
    step();
    req_issued      = 1'b0;
  endtask

  // kind: 1 prefetch payload, 0 load payload, -1 no payload expected
  task automatic add_frame(input logic [1:0] sbs, input logic [15:0] data, input int kind, input int nbeats);
    ev_t e;
    int  base;
    base = seq.size();
    e = '0; e.cyc = base; e.st = 1'b1; e.pins = 2'b10;
    tmpl.push_back(e); seq.push_back(2'b10);
    e = '0; e.cyc = base + 1; e.sv = 1'b1; e.act = 1'b1; e.pins = sbs;
    tmpl.push_back(e); seq.push_back(sbs);
    if (kind >= 0) begin
      for (int b = 0; b < nbeats; b++) begin
        e = '0;
        e.cyc  = base + 2 + b;
        e.act  = 1'b1;
        e.dv   = (kind == 1);
        e.ldv  = (kind == 0);
        e.cnt  = 4'(b);
        e.dn   = (kind == 1) && (b == 7);
        e.ldn  = (kind == 0) && (b == 7);
        e.pins = data[2*b +: 2];
        tmpl.push_back(e);
        seq.push_back(data[2*b +: 2]);
      end
    end
  endtask

  task automatic run_seq(input int push_idx, input logic push_kind);
    ev_t e;
    int  n;
    n = seq.size();
    for (int i = 0; i < n + LAT; i++) begin
      rx_pins         = (i < n) ? seq[i] : 2'b11;
      req_issued      = (i == push_idx);
      req_is_prefetch = push_kind;
      while (tmpl.size() > 0 && tmpl[0].cyc == i) begin
        e     = tmpl.pop_front();
        e.cyc = cyc + LAT;
        sb.push_back(e);
      end
      step();
    end
    rx_pins    = 2'b11;
    req_issued = 1'b0;
    seq.delete();
  endtask

  always @(negedge clk) begin
    ev_t got;
    ev_t e;
    if (reset && (rx_started || rx_sbs_valid || rx_data_valid || rx_ldata_valid || rx_done || rx_ldone)) begin
      got = '0;
      got.cyc = cyc; got.st = rx_started; got.act = rx_active; got.sv = rx_sbs_valid;
      got.dv = rx_data_valid; got.ldv = rx_ldata_valid; got.cnt = rx_counter;
      got.dn = rx_done; got.ldn = rx_ldone;
`ifdef RX_PIN_SYNC_EN
      got.pins = rx_pins_synced;
`endif
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected cyc=%0d st=%b sv=%b dv=%b ldv=%b cnt=%0d dn=%b ldn=%b",
                 cyc, rx_started, rx_sbs_valid, rx_data_valid, rx_ldata_valid, rx_counter, rx_done, rx_ldone);
      end else begin
        e = sb.pop_front();
`ifndef RX_PIN_SYNC_EN
        e.pins = '0;
`endif
        if (got !== e) begin
          bad++;
          $display("FAIL sb_event got cyc=%0d st=%b act=%b sv=%b dv=%b ldv=%b cnt=%0d dn=%b ldn=%b pins=%b exp cyc=%0d st=%b act=%b sv=%b dv=%b ldv=%b cnt=%0d dn=%b ldn=%b pins=%b",
                   got.cyc, got.st, got.act, got.sv, got.dv, got.ldv, got.cnt, got.dn, got.ldn, got.pins,
                   e.cyc, e.st, e.act, e.sv, e.dv, e.ldv, e.cnt, e.dn, e.ldn, e.pins);
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_started"},  32'(rx_started),     0);
    chk({tag, "_active"},   32'(rx_active),      0);
    chk({tag, "_sbs_vld"},  32'(rx_sbs_valid),   0);
    chk({tag, "_dv"},       32'(rx_data_valid),  0);
    chk({tag, "_ldv"},      32'(rx_ldata_valid), 0);
    chk({tag, "_counter"},  32'(rx_counter),     0);
    chk({tag, "_done"},     32'(rx_done),        0);
    chk({tag, "_ldone"},    32'(rx_ldone),       0);
    chk({tag, "_full"},     32'(queue_full),     0);
    chk({tag, "_err"},      32'(protocol_error), 0);
    chk({tag, "_sbs"},      32'(rx_sbs),         0);
  endtask

  initial begin
    reset           = 1'b0;
    rx_pins         = 2'b10;
    req_issued      = 1'b0;
    req_is_prefetch = 1'b0;
    #7;
    chk_all_zero("rst");
    rx_pins = 2'b11;
    @(negedge clk);
    reset = 1'b1;
    step();
    step();

    // single prefetch frame
    issue(1'b1);
    add_frame(2'b01, 16'h1234, 1, 8);
    run_seq(-1, 1'b0);
    chk("s1_sbs", 32'(rx_sbs), 32'h1);
    chk("s1_active", 32'(rx_active), 0);
    chk("s1_counter", 32'(rx_counter), 0);

    // load then prefetch, back-to-back frames
    issue(1'b0);
    issue(1'b1);
    add_frame(2'b01, 16'hA5C3, 0, 8);
    add_frame(2'b01, 16'h0F0F, 1, 8);
    run_seq(-1, 1'b0);
    chk("s2_err", 32'(protocol_error), 0);

    // non-read SBS values abort without error or pop
    add_frame(2'b11, 16'h0, -1, 0);
    run_seq(-1, 1'b0);
    chk("s3_err", 32'(protocol_error), 0);
    chk("s3_sbs", 32'(rx_sbs), 32'h3);
    issue(1'b1);
    add_frame(2'b10, 16'h0, -1, 0);
    add_frame(2'b01, 16'h8001, 1, 8);
    run_seq(-1, 1'b0);
    chk("s3b_err", 32'(protocol_error), 0);

    // fill queue, push+pop at full, overflow drop
    issue(1'b0);
    chk("s4_full1", 32'(queue_full), 0);
    issue(1'b1);
    issue(1'b0);
    chk("s4_full3", 32'(queue_full), 1);
    chk("s4_err0", 32'(protocol_error), 0);
    add_frame(2'b01, 16'hBEEF, 0, 8);
    run_seq(9 + LAT, 1'b1);
    chk("s4_full_pp", 32'(queue_full), 1);
    chk("s4_err_pp", 32'(protocol_error), 0);
    issue(1'b0);
    chk("s4_err_ovf", 32'(protocol_error), 1);
    chk("s4_full_ovf", 32'(queue_full), 1);
    add_frame(2'b01, 16'h1111, 1, 8);
    add_frame(2'b01, 16'h2222, 0, 8);
    add_frame(2'b01, 16'h3333, 1, 8);
    run_seq(-1, 1'b0);
    chk("s4_drained", 32'(queue_full), 0);

    // async reset mid-payload
    issue(1'b1);
    add_frame(2'b01, 16'hC0DE, 1, 4);
    run_seq(-1, 1'b0);
    #2;
    chk("s5_cnt4", 32'(rx_counter), 4);
    chk("s5_dv", 32'(rx_data_valid), 1);
    reset = 1'b0;
    #1;
    chk_all_zero("s5");
    @(negedge clk);
    reset = 1'b1;
    step();
    step();

    // queue was flushed: read SBS now flags an error
    chk("s6_err0", 32'(protocol_error), 0);
    add_frame(2'b01, 16'h0, -1, 0);
    run_seq(-1, 1'b0);
    chk("s6_err1", 32'(protocol_error), 1);
    chk("s6_active", 32'(rx_active), 0);
    chk("s6_full", 32'(queue_full), 0);

    step();
    step();
    chk("sb_leftover", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
